// File: rtl/flash_boot_loader.sv
// flash_boot_loader
//   Post-reset sequencer. It holds the core in reset and wakes the SPI flash with 0xAB.
//   It then issues a single 0x03 READ at FLASH_ADDR and streams N_WORDS little-endian
//   32-bit words into the bootram write port. Finally it returns the flash pads to GPIO
//   and releases the core.
// Ports
//   clk_sys, rst_n (sync, active low)
//   skip          : sampled in IDLE, 1 = go straight to DONE
//   flash_miso    : flash data in; flash_sclk/flash_mosi/flash_cs_n : SPI mode 0 master
//   pad_override  : 1 while the loader owns the flash pads
//   ram_waddr/ram_wdata/ram_wen : bootram write port (wen is a 1-cycle pulse)
//   done, core_rst_n : load complete / core reset release (both sticky until reset)
module flash_boot_loader #(
  parameter logic [23:0] FLASH_ADDR = 24'h020000,
  parameter int          N_WORDS    = 512,
  parameter int          W_ADDR     = 9,
  parameter int          CLKDIV     = 2,
  parameter int          T_WAKE     = 40
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic              skip,
  input  logic              flash_miso,
  output logic              flash_sclk,
  output logic              flash_mosi,
  output logic              flash_cs_n,
  output logic              pad_override,
  output logic [W_ADDR-1:0] ram_waddr,
  output logic [31:0]       ram_wdata,
  output logic              ram_wen,
  output logic              done,
  output logic              core_rst_n
);
  if (N_WORDS < 1 || N_WORDS > (1 << W_ADDR)) begin : g_bad_n_words
    $error("flash_boot_loader: N_WORDS must be in 1..2**W_ADDR");
  end
  if (CLKDIV < 1 || T_WAKE < 1) begin : g_bad_timing
    $error("flash_boot_loader: CLKDIV and T_WAKE must be >= 1");
  end

  localparam int DW  = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int GW  = $clog2(T_WAKE + 1);
  localparam int WCW = W_ADDR + 1;
  localparam logic [DW-1:0]     DIV_LAST  = DW'(CLKDIV - 1);
  localparam logic [GW-1:0]     GAP_LAST  = GW'(T_WAKE - 1);
  localparam logic [WCW-1:0]    WORD_LAST = WCW'(N_WORDS - 1);
  localparam logic [W_ADDR-1:0] ADDR_LAST = W_ADDR'(N_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAKE_CMD, S_WAKE_GAP, S_READ_CMD, S_DATA, S_FINISH, S_DONE
  } state_t;

  state_t         state, state_n;
  logic           idle_go;   // IDLE holds one full cycle after reset release
  logic           sclk_q;
  logic [DW-1:0]  div_cnt;
  logic [GW-1:0]  gap_cnt;
  logic [4:0]     bit_cnt;   // bit within the current byte-group / word (wraps per word)
  logic [WCW-1:0] word_cnt;
  logic           tail;      // trailing low half before cs_n rises
  logic [31:0]    tx_sr, rx_sr;
  logic           wen_pend;

  logic shifting, half_end, rise, fall, last_bit;

  assign shifting = (state == S_WAKE_CMD) || (state == S_READ_CMD) || (state == S_DATA);
  assign half_end = (div_cnt == DIV_LAST);
  assign rise     = shifting && !tail && half_end && !sclk_q;
  assign fall     = shifting && half_end && sclk_q;

  always_comb begin
    state_n  = state;
    last_bit = 1'b0;
    case (state)
      S_WAKE_CMD: last_bit = (bit_cnt == 5'd7);
      S_READ_CMD: last_bit = (bit_cnt == 5'd31);
      S_DATA:     last_bit = (bit_cnt == 5'd31) && (word_cnt == WORD_LAST);
      default:    last_bit = 1'b0;
    endcase
    case (state)
      S_IDLE:     if (idle_go) state_n = skip ? S_DONE : S_WAKE_CMD;
      S_WAKE_CMD: if (tail && half_end) state_n = S_WAKE_GAP;
      S_WAKE_GAP: if (gap_cnt == GAP_LAST) state_n = S_READ_CMD;
      // The last command falling edge opens the first data low half: cs_n stays low.
      S_READ_CMD: if (fall && last_bit) state_n = S_DATA;
      S_DATA:     if (tail && half_end) state_n = S_FINISH;
      S_FINISH:   state_n = S_DONE;
      default:    state_n = S_DONE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idle_go   <= 1'b0;
      sclk_q    <= 1'b0;
      div_cnt   <= '0;
      gap_cnt   <= '0;
      bit_cnt   <= '0;
      word_cnt  <= '0;
      tail      <= 1'b0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      wen_pend  <= 1'b0;
      ram_wen   <= 1'b0;
      ram_wdata <= '0;
      ram_waddr <= '0;
    end else begin
      state    <= state_n;
      idle_go  <= 1'b1;
      // Word completes on the rising edge of its 32nd bit; write lands one cycle later.
      wen_pend <= rise && (state == S_DATA) && (bit_cnt == 5'd31);
      ram_wen  <= wen_pend;
      if (wen_pend) ram_wdata <= {rx_sr[7:0], rx_sr[15:8], rx_sr[23:16], rx_sr[31:24]};
      if (ram_wen && ram_waddr != ADDR_LAST) ram_waddr <= ram_waddr + 1'b1;

      if (state_n != state) begin
        sclk_q   <= 1'b0;
        div_cnt  <= '0;
        gap_cnt  <= '0;
        bit_cnt  <= '0;
        word_cnt <= '0;
        tail     <= 1'b0;
        if (state_n == S_WAKE_CMD)      tx_sr <= {8'hAB, 24'h0};
        else if (state_n == S_READ_CMD) tx_sr <= {8'h03, FLASH_ADDR};
      end else begin
        if (state == S_WAKE_GAP) gap_cnt <= gap_cnt + 1'b1;
        if (shifting) div_cnt <= half_end ? '0 : div_cnt + 1'b1;
        if (rise || fall) sclk_q <= ~sclk_q;
        if (rise && state == S_DATA) rx_sr <= {rx_sr[30:0], flash_miso};
        if (fall) begin
          bit_cnt <= bit_cnt + 1'b1;
          tx_sr   <= {tx_sr[30:0], 1'b0};   // mosi moves at the start of the low half
          if (state == S_DATA && bit_cnt == 5'd31) word_cnt <= word_cnt + 1'b1;
          if (last_bit) tail <= 1'b1;
        end
      end
    end
  end

  assign flash_sclk   = sclk_q;
  assign flash_cs_n   = !shifting;
  assign flash_mosi   = ((state == S_WAKE_CMD) || (state == S_READ_CMD)) && tx_sr[31];
  assign pad_override = (state != S_DONE);
  assign done         = (state == S_DONE);
  assign core_rst_n   = (state == S_DONE);
endmodule
